freelist: RTL and testbench
===========================

Name: freelist

Overview:
- Physical-register free list for the rename stage; sits directly upstream of the ROB.
- Rename allocates up to RENAME_WIDTH destination pregs per cycle. Retire returns up to COMMIT_WIDTH stale pregs per cycle.
- Circular FIFO of preg_addr_t with speculative head, committed head and tail pointers.
- On pipeline flush, all uncommitted allocations are reclaimed in one cycle by restoring head to the committed head.

Parameters:
- PREG_NUM, 64, number of physical registers; power of two.
- AREG_NUM, 32, number of architectural registers; identity-mapped at reset.
- RENAME_WIDTH, 4, allocation lanes per cycle.
- COMMIT_WIDTH, 4, free/commit lanes per cycle.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- alloc_req  in  RENAME_WIDTH  per-lane allocation request; any bit pattern allowed.
- alloc_ready  out  1  all requested lanes can be served this cycle.
- alloc_preg  out  RENAME_WIDTH*$clog2(PREG_NUM)  preg per lane, lane i in bits [i*W+:W]; valid only where alloc_req[i] is set.
- free_valid  in  COMMIT_WIDTH  per-lane free from retire.
- free_preg  in  COMMIT_WIDTH*$clog2(PREG_NUM)  stale preg per lane.
- commit_alloc_cnt  in  $clog2(COMMIT_WIDTH)+1  number of retiring instructions this cycle that had allocated a preg.
- flush  in  1  mispredict/exception recovery.
- free_count  out  $clog2(PREG_NUM)+1  current speculative free entries.
- fl_err  out  1  sticky error flag; functional only with FREELIST_CHECK_EN.

Behaviour:
- Storage and pointers
  - Storage: PREG_NUM entries.
  - Pointers head, arch_head and tail are $clog2(PREG_NUM)+1 bits wide (extra wrap bit).
  - Index = low bits; arithmetic is modulo 2^(W+1).
  - free_count = tail - head.
- Reset (synchronous, clk edge with reset=1)
  - entry[k] = AREG_NUM+k for k < PREG_NUM-AREG_NUM; remaining entries are don't-care.
  - head = arch_head = 0; tail = PREG_NUM-AREG_NUM.
  - free_count = 32, alloc_ready = 1, fl_err = 0.
  - Reset overrides flush, alloc and free in the same cycle.
- Allocation (combinational outputs, registered pointer update)
  - n = popcount(alloc_req).
  - Lane i receives entry[head + number of set request bits below lane i]; requests are compacted, so lanes need not be contiguous.
  - alloc_ready = (free_count >= n) && !flush.
  - Allocation fires when alloc_ready && n > 0; head += n at the next edge.
  - All-or-nothing: when alloc_ready=0, head is unchanged and rename stalls.
  - alloc_ready is computed from registered free_count only. Same-cycle frees do not forward into allocation.
- Free
  - m = popcount(free_valid). Valid lanes are compacted and written to entry[tail], entry[tail+1], ... in lane order.
  - tail += m at the next edge.
  - A free never overflows: the free list plus in-flight allocations always equal PREG_NUM-AREG_NUM. No back-pressure on retire.
- Commit
  - arch_head += commit_alloc_cnt each cycle.
  - Caller guarantees arch_head never passes head.
- Flush
  - head <= arch_head + commit_alloc_cnt, i.e. the post-commit value of the same cycle.
  - No allocation is performed that cycle.
  - Frees and commit in the same cycle are still applied.
  - Next cycle: free_count = tail' - head'.
- Simultaneous alloc, free and commit: all apply independently in one cycle.
- Wrap-around: index wraps at PREG_NUM. The wrap bit distinguishes full from empty.
- Empty: free_count=0 → alloc_ready=0 for any n>0; n=0 is always ready unless flush.

Optional Feature:
- Macro: FREELIST_CHECK_EN.
- Defined
  - Keeps an in_list bitmap of PREG_NUM bits; reset sets bits AREG_NUM..PREG_NUM-1.
  - Alloc clears the bit; free sets it.
  - Flush re-sets the bits for entries between arch_head and the old head.
  - fl_err is set (sticky until reset) when a free targets a preg whose bit is already 1, or when two lanes free the same preg in one cycle.
- Undefined: no bitmap logic; fl_err tied to 0.

Decomposition:
- rename_pkg holds: PREG_NUM, AREG_NUM, RENAME_WIDTH, COMMIT_WIDTH, preg_addr_t, fl_ptr_t (W+1 bits).
- One sub-module, lane_compact: mask in → per-lane prefix offsets plus popcount. Instantiated twice, once for alloc lanes and once for free lanes.

Test Plan:
- Reset, then alloc_req=4'b1111 → alloc_preg={35,34,33,32} (lane3..lane0), alloc_ready=1; next cycle free_count=28.
- alloc_req=4'b1010 with head at preg 32 → lane1=32, lane3=33; head+=2.
- Drain to free_count=2, then alloc_req=4'b0111 → alloc_ready=0, head unchanged. Free 2 pregs, next cycle request → ready.
- Alloc 8 pregs with no commits, commit_alloc_cnt=3, then flush → next cycle free_count=32-3=29; next alloc returns the preg after the 3 committed ones.
- Push tail past index 63 with frees {5,6,7} → entries wrap to indices 0..2 and are later allocated in order 5,6,7.
- With FREELIST_CHECK_EN: free preg 40 while 40 is still in the list → fl_err=1 next cycle and stays 1 until reset.

Source files
------------

// File: rtl/rename_pkg.sv
// Shared rename-stage types and sizing for the physical-register free list.
package rename_pkg;

  localparam int unsigned PREG_NUM     = 64;
  localparam int unsigned AREG_NUM     = 32;
  localparam int unsigned RENAME_WIDTH = 4;
  localparam int unsigned COMMIT_WIDTH = 4;

  localparam int unsigned PREG_W = $clog2(PREG_NUM);

  typedef logic [PREG_W-1:0] preg_addr_t;
  // One extra wrap bit so that full and empty are distinguishable.
  typedef logic [PREG_W:0]   fl_ptr_t;

endpackage

// File: rtl/lane_compact.sv
// Lane compaction helper: for each lane, the number of set mask bits below it,
// plus the total popcount of the mask.
module lane_compact #(
  parameter int unsigned Width = 4,
  parameter int unsigned CntW  = $clog2(Width) + 1
) (
  input  logic [Width-1:0]           mask,
  output logic [Width-1:0][CntW-1:0] offset,
  output logic [CntW-1:0]            count
);

  // Running prefix sum over the mask bits, lane 0 first.
  always_comb begin
    logic [CntW-1:0] acc;
    acc    = '0;
    offset = '0;
    for (int i = 0; i < int'(Width); i++) begin
      offset[i] = acc;
      acc       = acc + CntW'(mask[i]);
    end
    count = acc;
  end

endmodule

// File: rtl/freelist.sv
// Physical-register free list: circular FIFO with speculative head, committed
// head and tail pointers. Flush restores head to the post-commit committed head.
// Optional consistency checking (in_list bitmap, sticky fl_err) is built when
// FREELIST_CHECK_EN is defined; otherwise fl_err is tied low.
module freelist
  import rename_pkg::*;
(
  input  logic                             clk,
  input  logic                             reset,
  input  logic [RENAME_WIDTH-1:0]          alloc_req,
  output logic                             alloc_ready,
  output logic [RENAME_WIDTH*PREG_W-1:0]   alloc_preg,
  input  logic [COMMIT_WIDTH-1:0]          free_valid,
  input  logic [COMMIT_WIDTH*PREG_W-1:0]   free_preg,
  input  logic [$clog2(COMMIT_WIDTH):0]    commit_alloc_cnt,
  input  logic                             flush,
  output fl_ptr_t                          free_count,
  output logic                             fl_err
);

  localparam int unsigned ACntW = $clog2(RENAME_WIDTH) + 1;
  localparam int unsigned FCntW = $clog2(COMMIT_WIDTH) + 1;

  preg_addr_t mem_q [PREG_NUM];
  preg_addr_t mem_d [PREG_NUM];
  fl_ptr_t    head_q, head_d;
  fl_ptr_t    arch_head_q, arch_head_d;
  fl_ptr_t    tail_q, tail_d;

  logic [RENAME_WIDTH-1:0][ACntW-1:0] a_off;
  logic [ACntW-1:0]                   a_cnt;
  logic [COMMIT_WIDTH-1:0][FCntW-1:0] f_off;
  logic [FCntW-1:0]                   f_cnt;

  preg_addr_t alloc_lane [RENAME_WIDTH];
  preg_addr_t free_lane  [COMMIT_WIDTH];
  preg_addr_t free_idx   [COMMIT_WIDTH];
  logic       alloc_fire;

  lane_compact #(.Width(RENAME_WIDTH), .CntW(ACntW)) u_alloc_compact (
    .mask   (alloc_req),
    .offset (a_off),
    .count  (a_cnt)
  );

  lane_compact #(.Width(COMMIT_WIDTH), .CntW(FCntW)) u_free_compact (
    .mask   (free_valid),
    .offset (f_off),
    .count  (f_cnt)
  );

  assign free_count  = tail_q - head_q;
  // Readiness uses registered occupancy only; same-cycle frees do not forward.
  assign alloc_ready = (free_count >= fl_ptr_t'(a_cnt)) && !flush;
  assign alloc_fire  = alloc_ready && (a_cnt != '0);

  // Compacted read of allocation lanes starting at the speculative head.
  always_comb begin
    alloc_preg = '0;
    for (int i = 0; i < int'(RENAME_WIDTH); i++) begin
      alloc_lane[i] = mem_q[preg_addr_t'(head_q + fl_ptr_t'(a_off[i]))];
      alloc_preg[i*PREG_W +: PREG_W] = alloc_lane[i];
    end
  end

  // Split free lanes and compute their compacted write slots after tail.
  always_comb begin
    for (int i = 0; i < int'(COMMIT_WIDTH); i++) begin
      free_lane[i] = free_preg[i*PREG_W +: PREG_W];
      free_idx[i]  = preg_addr_t'(tail_q + fl_ptr_t'(f_off[i]));
    end
  end

  // Pointer next-state: commit always advances; flush beats allocation.
  always_comb begin
    arch_head_d = arch_head_q + fl_ptr_t'(commit_alloc_cnt);
    tail_d      = tail_q + fl_ptr_t'(f_cnt);
    head_d      = head_q;
    if (flush) begin
      head_d = arch_head_d;
    end else if (alloc_fire) begin
      head_d = head_q + fl_ptr_t'(a_cnt);
    end
  end

  // Storage next-state: reset reloads the identity-free pregs, else frees append.
  always_comb begin
    mem_d = mem_q;
    if (reset) begin
      for (int k = 0; k < int'(PREG_NUM); k++) begin
        mem_d[k] = preg_addr_t'(AREG_NUM + k);
      end
    end else begin
      for (int i = 0; i < int'(COMMIT_WIDTH); i++) begin
        if (free_valid[i]) mem_d[free_idx[i]] = free_lane[i];
      end
    end
  end

  // Storage register.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Pointer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q      <= '0;
      arch_head_q <= '0;
      tail_q      <= fl_ptr_t'(PREG_NUM - AREG_NUM);
    end else begin
      head_q      <= head_d;
      arch_head_q <= arch_head_d;
      tail_q      <= tail_d;
    end
  end

`ifdef FREELIST_CHECK_EN
  localparam logic [PREG_NUM-1:0] InListRst =
    {{(PREG_NUM - AREG_NUM){1'b1}}, {AREG_NUM{1'b0}}};

  logic [PREG_NUM-1:0] in_list_q, in_list_d;
  logic                err_q, err_d;
  fl_ptr_t             span;

  // Entries reclaimed by a flush lie between the post-commit head and old head.
  assign span = head_q - arch_head_d;

  // Membership tracking and duplicate-free detection.
  always_comb begin
    in_list_d = in_list_q;
    err_d     = err_q;
    if (alloc_fire) begin
      for (int i = 0; i < int'(RENAME_WIDTH); i++) begin
        if (alloc_req[i]) in_list_d[alloc_lane[i]] = 1'b0;
      end
    end
    if (flush) begin
      for (int j = 0; j < int'(PREG_NUM); j++) begin
        if (fl_ptr_t'(j) < span) begin
          in_list_d[mem_q[preg_addr_t'(arch_head_d + fl_ptr_t'(j))]] = 1'b1;
        end
      end
    end
    for (int i = 0; i < int'(COMMIT_WIDTH); i++) begin
      if (free_valid[i]) begin
        if (in_list_q[free_lane[i]]) err_d = 1'b1;
        for (int k = 0; k < i; k++) begin
          if (free_valid[k] && (free_lane[k] == free_lane[i])) err_d = 1'b1;
        end
        in_list_d[free_lane[i]] = 1'b1;
      end
    end
  end

  // Bitmap and sticky error registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_list_q <= InListRst;
      err_q     <= 1'b0;
    end else begin
      in_list_q <= in_list_d;
      err_q     <= err_d;
    end
  end

  assign fl_err = err_q;
`else
  assign fl_err = 1'b0;
`endif

endmodule

// File: tb/tb_freelist.sv
// Scoreboard bench for freelist: stimulus pushes per-cycle expectations, a
// negedge monitor pops and compares them against the DUT outputs.
module tb_freelist;
  import rename_pkg::*;

`ifdef FREELIST_CHECK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  alloc_req = '0;
  logic        alloc_ready;
  logic [23:0] alloc_preg;
  logic [3:0]  free_valid = '0;
  logic [23:0] free_preg = '0;
  logic [2:0]  commit_alloc_cnt = '0;
  logic        flush = 1'b0;
  fl_ptr_t     free_count;
  logic        fl_err;

  freelist dut (
    .clk              (clk),
    .reset            (reset),
    .alloc_req        (alloc_req),
    .alloc_ready      (alloc_ready),
    .alloc_preg       (alloc_preg),
    .free_valid       (free_valid),
    .free_preg        (free_preg),
    .commit_alloc_cnt (commit_alloc_cnt),
    .flush            (flush),
    .free_count       (free_count),
    .fl_err           (fl_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  req;
    int          exp_cnt;
    int          exp_rdy;
    logic [23:0] exp_p;
    logic        exp_err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [23:0] pk(input int l0, input int l1, input int l2, input int l3);
    logic [5:0] a, b, c, d;
    a = 6'(l0);
    b = 6'(l1);
    c = 6'(l2);
    d = 6'(l3);
    return {d, c, b, a};
  endfunction

  // Monitor: one expectation per driven cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t        r;
      logic [23:0] m;
      r = sb.pop_front();
      m = '0;
      for (int i = 0; i < 4; i++) if (r.req[i]) m[i*6 +: 6] = 6'h3f;
      if (r.exp_cnt >= 0) check({r.name, ".free_count"}, int'(free_count), r.exp_cnt);
      if (r.exp_rdy >= 0) check({r.name, ".alloc_ready"}, int'(alloc_ready), r.exp_rdy);
      if (r.exp_rdy == 1 && r.req != '0)
        check({r.name, ".alloc_preg"}, int'(alloc_preg & m), int'(r.exp_p & m));
      check({r.name, ".fl_err"}, int'(fl_err), int'(r.exp_err));
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    alloc_req = '0; free_valid = '0; free_preg = '0; commit_alloc_cnt = '0; flush = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic cyc(input string name, input logic [3:0] req, input logic [3:0] fv,
                     input logic [23:0] fp, input logic [2:0] cac, input logic fl,
                     input int exp_cnt, input int exp_rdy, input logic [23:0] exp_p,
                     input logic exp_err);
    exp_t r;
    @(posedge clk); #1;
    alloc_req = req; free_valid = fv; free_preg = fp; commit_alloc_cnt = cac; flush = fl;
    r.name = name; r.req = req; r.exp_cnt = exp_cnt; r.exp_rdy = exp_rdy;
    r.exp_p = exp_p; r.exp_err = exp_err;
    sb.push_back(r);
  endtask

  initial begin
    do_reset();
    // Basic allocation, sparse lanes, drain to near-empty, stall then recover.
    cyc("a_all4", 4'b1111, 4'b0, '0, 3'd0, 1'b0, 32, 1, pk(32, 33, 34, 35), 1'b0);
    cyc("a_sparse", 4'b1010, 4'b0, '0, 3'd0, 1'b0, 28, 1, pk(0, 36, 0, 37), 1'b0);
    for (int k = 0; k < 6; k++)
      cyc("a_drain", 4'b1111, 4'b0, '0, 3'd0, 1'b0, 26 - 4*k, 1,
          pk(38 + 4*k, 39 + 4*k, 40 + 4*k, 41 + 4*k), 1'b0);
    cyc("a_stall", 4'b0111, 4'b0, '0, 3'd0, 1'b0, 2, 0, '0, 1'b0);
    cyc("a_stall_free", 4'b0111, 4'b0011, pk(1, 2, 0, 0), 3'd0, 1'b0, 2, 0, '0, 1'b0);
    cyc("a_resume", 4'b0111, 4'b0, '0, 3'd0, 1'b0, 4, 1, pk(62, 63, 1, 0), 1'b0);
    cyc("a_idle", 4'b0000, 4'b0, '0, 3'd0, 1'b0, 1, 1, '0, 1'b0);

    // Flush recovery with same-cycle commit, then simultaneous alloc/free/commit.
    do_reset();
    cyc("b_alloc0", 4'b1111, 4'b0, '0, 3'd0, 1'b0, 32, 1, pk(32, 33, 34, 35), 1'b0);
    cyc("b_alloc1", 4'b1111, 4'b0, '0, 3'd0, 1'b0, 28, 1, pk(36, 37, 38, 39), 1'b0);
    cyc("b_flush", 4'b1111, 4'b0, '0, 3'd3, 1'b1, 24, 0, '0, 1'b0);
    cyc("b_post", 4'b0001, 4'b0, '0, 3'd0, 1'b0, 29, 1, pk(35, 0, 0, 0), 1'b0);
    cyc("b_mixed", 4'b0011, 4'b0101, pk(3, 0, 4, 0), 3'd1, 1'b0, 28, 1,
        pk(36, 37, 0, 0), 1'b0);
    cyc("b_after", 4'b0000, 4'b0, '0, 3'd0, 1'b0, 28, 1, '0, 1'b0);
    cyc("b_flush2", 4'b0000, 4'b0, '0, 3'd0, 1'b1, 28, 0, '0, 1'b0);
    cyc("b_after2", 4'b0000, 4'b0, '0, 3'd0, 1'b0, 30, 1, '0, 1'b0);

    // Empty boundary and tail wrap-around past index 63.
    do_reset();
    for (int k = 0; k < 8; k++)
      cyc("c_empty", 4'b1111, 4'b0, '0, 3'd0, 1'b0, 32 - 4*k, 1,
          pk(32 + 4*k, 33 + 4*k, 34 + 4*k, 35 + 4*k), 1'b0);
    cyc("c_empty_req", 4'b0001, 4'b0, '0, 3'd0, 1'b0, 0, 0, '0, 1'b0);
    cyc("c_empty_n0", 4'b0000, 4'b0, '0, 3'd0, 1'b0, 0, 1, '0, 1'b0);
    for (int k = 0; k < 8; k++)
      cyc("c_refill", 4'b0000, 4'b1111, pk(32 + 4*k, 33 + 4*k, 34 + 4*k, 35 + 4*k),
          3'd0, 1'b0, 4*k, 1, '0, 1'b0);
    cyc("c_wrapfree", 4'b0000, 4'b0111, pk(5, 6, 7, 0), 3'd0, 1'b0, 32, 1, '0, 1'b0);
    for (int k = 0; k < 8; k++)
      cyc("c_realloc", 4'b1111, 4'b0, '0, 3'd0, 1'b0, 35 - 4*k, 1,
          pk(32 + 4*k, 33 + 4*k, 34 + 4*k, 35 + 4*k), 1'b0);
    cyc("c_wrapalloc", 4'b0111, 4'b0, '0, 3'd0, 1'b0, 3, 1, pk(5, 6, 7, 0), 1'b0);
    cyc("c_final", 4'b0001, 4'b0, '0, 3'd0, 1'b0, 0, 0, '0, 1'b0);

    // Error flag: double free of a listed preg, then duplicate lanes.
    do_reset();
    cyc("d_dfree", 4'b0000, 4'b0001, pk(40, 0, 0, 0), 3'd0, 1'b0, 32, 1, '0, 1'b0);
    cyc("d_err", 4'b0000, 4'b0, '0, 3'd0, 1'b0, 33, 1, '0, ChkEn);
    cyc("d_sticky", 4'b0000, 4'b0, '0, 3'd0, 1'b0, 33, 1, '0, ChkEn);
    do_reset();
    cyc("d_clear", 4'b0000, 4'b0011, pk(1, 1, 0, 0), 3'd0, 1'b0, 32, 1, '0, 1'b0);
    cyc("d_dup", 4'b0000, 4'b0, '0, 3'd0, 1'b0, 34, 1, '0, ChkEn);

    @(posedge clk); #1;
    alloc_req = '0; free_valid = '0; flush = 1'b0; commit_alloc_cnt = '0;
    repeat (3) @(posedge clk);
    check("sb_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
